// File: rtl/neuron_axon_sweep_counter.sv
// Two-level (neuron, axon) index sweep with start/done handshake, limits latched at start,
// and a downstream stall that holds the current beat.
module neuron_axon_sweep_counter #(
  parameter int NEURON_WIDTH = 8,
  parameter int AXON_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NEURON_WIDTH-1:0] cfg_last_neuron,
  input  logic [AXON_WIDTH-1:0]   cfg_last_axon,
  input  logic                    stall,
  output logic [NEURON_WIDTH-1:0] neuron_idx,
  output logic [AXON_WIDTH-1:0]   axon_idx,
  output logic                    valid,
  output logic                    axon_last,
  output logic                    neuron_last,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              state_dbg
);

  // Handshake: a beat is the (neuron_idx, axon_idx) pair while valid=1; the consumer is
  // ready when stall=0, and a beat transfers on any edge with valid=1 && stall=0.
  // While valid=1 && stall=1 the beat and all state are held unchanged.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NEURON_WIDTH-1:0] neuron_q, neuron_d;
  logic [AXON_WIDTH-1:0]   axon_q, axon_d;
  logic [NEURON_WIDTH-1:0] last_neuron_q, last_neuron_d;
  logic [AXON_WIDTH-1:0]   last_axon_q, last_axon_d;

  always_comb begin
    state_d       = state_q;
    neuron_d      = neuron_q;
    axon_d        = axon_q;
    last_neuron_d = last_neuron_q;
    last_axon_d   = last_axon_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          last_neuron_d = cfg_last_neuron;
          last_axon_d   = cfg_last_axon;
          neuron_d      = '0;
          axon_d        = '0;
          state_d       = SWEEP;
        end
      end
      SWEEP: begin
        if (!stall) begin
          // Equality against the latched limits keeps indices in range even at all-ones.
          if (axon_q != last_axon_q) begin
            axon_d = axon_q + AXON_WIDTH'(1);
          end else if (neuron_q != last_neuron_q) begin
            axon_d   = '0;
            neuron_d = neuron_q + NEURON_WIDTH'(1);
          end else begin
            axon_d   = '0;
            neuron_d = '0;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      neuron_q      <= '0;
      axon_q        <= '0;
      last_neuron_q <= '0;
      last_axon_q   <= '0;
    end else begin
      state_q       <= state_d;
      neuron_q      <= neuron_d;
      axon_q        <= axon_d;
      last_neuron_q <= last_neuron_d;
      last_axon_q   <= last_axon_d;
    end
  end

  always_comb begin
    neuron_idx  = neuron_q;
    axon_idx    = axon_q;
    valid       = (state_q == SWEEP);
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    axon_last   = valid && (axon_q == last_axon_q);
    neuron_last = valid && (neuron_q == last_neuron_q);
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_neuron_axon_sweep_counter.sv
// Directed bench for neuron_axon_sweep_counter (2-bit widths): a vector table for the
// basic sequences plus hand-written multi-cycle corner cases.
module tb_neuron_axon_sweep_counter;

  localparam int NW = 2;
  localparam int AW = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] cfg_last_neuron = '0;
  logic [AW-1:0] cfg_last_axon = '0;
  logic          stall = 1'b0;
  logic [NW-1:0] neuron_idx;
  logic [AW-1:0] axon_idx;
  logic          valid, axon_last, neuron_last, busy, done;
  logic [1:0]    state_dbg;

  neuron_axon_sweep_counter #(.NEURON_WIDTH(NW), .AXON_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_last_neuron(cfg_last_neuron),
    .cfg_last_axon(cfg_last_axon),
    .stall(stall),
    .neuron_idx(neuron_idx),
    .axon_idx(axon_idx),
    .valid(valid),
    .axon_last(axon_last),
    .neuron_last(neuron_last),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  typedef struct {
    logic          rst;
    logic          start;
    logic [NW-1:0] cn;
    logic [AW-1:0] ca;
    logic          stall;
    logic [NW-1:0] e_n;
    logic [AW-1:0] e_a;
    logic          e_v;
    logic          e_al;
    logic          e_nl;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic [NW-1:0] cn,
                              input logic [AW-1:0] ca, input logic st,
                              input logic [NW-1:0] en, input logic [AW-1:0] ea,
                              input logic ev, input logic eal, input logic enl,
                              input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.start = s; v.cn = cn; v.ca = ca; v.stall = st;
    v.e_n = en; v.e_a = ea; v.e_v = ev; v.e_al = eal; v.e_nl = enl;
    v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  // driver: apply inputs, let one rising edge pass, sample 1 time unit later
  task automatic step(input logic r, input logic s, input logic [NW-1:0] cn,
                      input logic [AW-1:0] ca, input logic st);
    rst = r; start = s; cfg_last_neuron = cn; cfg_last_axon = ca; stall = st;
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare of the full output bundle against a hand-derived expectation
  task automatic check(input string name, input logic [NW-1:0] en, input logic [AW-1:0] ea,
                       input logic ev, input logic eal, input logic enl,
                       input logic eb, input logic ed);
    n_vec++;
    if ({neuron_idx, axon_idx, valid, axon_last, neuron_last, busy, done} !==
        {en, ea, ev, eal, enl, eb, ed}) begin
      n_err++;
      $display("FAIL %s #%0d: got n=%0d a=%0d v=%b al=%b nl=%b busy=%b done=%b, want n=%0d a=%0d v=%b al=%b nl=%b busy=%b done=%b",
               name, n_vec, neuron_idx, axon_idx, valid, axon_last, neuron_last, busy, done,
               en, ea, ev, eal, enl, eb, ed);
    end
  endtask

  initial begin
    // reset, then 5 idle cycles
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // basic sweep 1/2: six beats, done, idle
    vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 2, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 0, 1, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 0, 1, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 0, 1, 2, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    // stall 3 cycles on (0,2), with start pulses and cfg changes mid-sweep
    vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3, 3, 0, 0, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3, 0, 1, 0, 2, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 3, 1, 0, 2, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 2, 1, 1, 0, 2, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 2, 1, 0, 1, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 3, 3, 0, 1, 2, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    // stall and start during DONE have no effect
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // cfg 0/0: one beat with both flags; stall in IDLE does not block start
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].cn, vecs[i].ca, vecs[i].stall);
      check("table", vecs[i].e_n, vecs[i].e_a, vecs[i].e_v, vecs[i].e_al, vecs[i].e_nl,
            vecs[i].e_busy, vecs[i].e_done);
    end

    // all-ones limits: 16 beats ending at (3,3), then done, no wrap with valid=1
    step(0, 1, 3, 3, 0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step(0, 0, 3, 3, 0);
      check("full", NW'(i / 4), AW'(i % 4), 1'b1, (i % 4) == 3, (i / 4) == 3, 1'b1, 1'b0);
    end
    step(0, 0, 3, 3, 0);
    check("full_done", 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 3, 3, 0);
    check("full_idle", 0, 0, 0, 0, 0, 0, 0);

    // reset at beat (1,0) aborts with no done pulse
    step(0, 1, 1, 2, 0);
    step(0, 0, 1, 2, 0);
    step(0, 0, 1, 2, 0);
    step(0, 0, 1, 2, 0);
    check("pre_abort", 1, 0, 1, 0, 1, 1, 0);
    step(1, 0, 1, 2, 0);
    check("abort", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0);
    check("abort_nodone", 0, 0, 0, 0, 0, 0, 0);

    // fresh full 6-beat sweep after the abort
    step(0, 1, 1, 2, 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(0, 0, 1, 2, 0);
      check("resweep", NW'(i / 3), AW'(i % 3), 1'b1, (i % 3) == 2, (i / 3) == 1, 1'b1, 1'b0);
    end
    step(0, 0, 1, 2, 0);
    check("resweep_done", 0, 0, 0, 0, 0, 1, 1);

    // rst and start together: rst wins
    step(1, 1, 1, 2, 0);
    check("rst_start", 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0);
    check("rst_start_idle", 0, 0, 0, 0, 0, 0, 0);

    // start held high: sweep 0/1, done, idle, then sweep with cfg 1/0 taken at its edge
    step(0, 1, 0, 1, 0);
    check("b2b_a0", 0, 0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 0, 0);
    check("b2b_a1", 0, 1, 1, 1, 1, 1, 0);
    step(0, 1, 1, 0, 0);
    check("b2b_adone", 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0);
    check("b2b_gap", 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    check("b2b_b0", 0, 0, 1, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    check("b2b_b1", 1, 0, 1, 1, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    check("b2b_bdone", 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0);
    check("b2b_idle", 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
